// File: rtl/frame_mem_write_arbiter.sv
// Purpose : owns the shared z-buffer/framebuffer write port; arbitrates between
//           fragment writes from the z-test stage and a frame-clear sweep engine.
// Latency : fragment accepted at edge E is written in the cycle after E; a clear
//           request sampled at E0 writes addresses 0..N-1 in cycles 1..N after E0.
// Backpressure: z_wr_ready drops while a clear is requested, active or pending;
//           the upstream holds its fragment until ready returns.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   clear_req, clear_color         start a clear sweep with the given {R,G,B}
//   clear_busy, clear_done         sweep active/pending, end-of-sweep pulse
//   z_wr_valid/ready/addr/depth/color  fragment write handshake and payload
//   z_wr_dropped                   accepted fragment had an out-of-frame address
//   zbuf_wen/waddr/wdata           z-buffer write port
//   fb_wen/waddr/wdata             framebuffer write port (same wen/addr as zbuf)

module frame_mem_write_arbiter #(
  parameter int          WIDTH   = 640,
  parameter int          HEIGHT  = 480,
  parameter logic [15:0] Z_CLEAR = 16'h7FFF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        clear_req,
  input  logic [23:0] clear_color,
  output logic        clear_busy,
  output logic        clear_done,

  input  logic        z_wr_valid,
  output logic        z_wr_ready,
  input  logic [19:0] z_wr_addr,
  input  logic [15:0] z_wr_depth,
  input  logic [23:0] z_wr_color,
  output logic        z_wr_dropped,

  output logic        zbuf_wen,
  output logic [19:0] zbuf_waddr,
  output logic [15:0] zbuf_wdata,

  output logic        fb_wen,
  output logic [19:0] fb_waddr,
  output logic [23:0] fb_wdata
);

  localparam int unsigned NPIX      = WIDTH * HEIGHT;
  // Sweep counter value once every address of the frame has been issued.
  localparam logic [18:0] SWEEP_END = 19'(NPIX);
  localparam logic [19:0] NPIX_ADDR = 20'(NPIX);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t      state_q, state_d;
  // Holds the address of the next sweep write. Address 0 is issued on the
  // request edge itself, so the counter is loaded with 1 at that point.
  logic [18:0] cnt_q, cnt_d;
  logic [23:0] color_q, color_d;
  logic        pend_q, pend_d;
  logic [23:0] pend_color_q, pend_color_d;

  logic        wen_q, wen_d;
  logic [19:0] waddr_q, waddr_d;
  logic [15:0] zdata_q, zdata_d;
  logic [23:0] fbdata_q, fbdata_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  // Colour for a back-to-back sweep: a request arriving on the final edge
  // overrides an earlier pending colour.
  logic [23:0] restart_color;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    color_d       = color_q;
    pend_d        = pend_q;
    pend_color_d  = pend_color_q;
    wen_d         = 1'b0;
    waddr_d       = waddr_q;
    zdata_d       = zdata_q;
    fbdata_d      = fbdata_q;
    done_d        = 1'b0;
    busy_d        = busy_q;
    drop_d        = 1'b0;
    restart_color = clear_req ? clear_color : pend_color_q;

    z_wr_ready    = (state_q == ST_IDLE) && !clear_req;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          // Clear wins over a simultaneous fragment; issue address 0 now.
          state_d  = ST_CLEAR;
          color_d  = clear_color;
          cnt_d    = 19'd1;
          pend_d   = 1'b0;
          busy_d   = 1'b1;
          wen_d    = 1'b1;
          waddr_d  = 20'd0;
          zdata_d  = Z_CLEAR;
          fbdata_d = clear_color;
        end else if (z_wr_valid) begin
          if (z_wr_addr < NPIX_ADDR) begin
            wen_d    = 1'b1;
            waddr_d  = z_wr_addr;
            zdata_d  = z_wr_depth;
            fbdata_d = z_wr_color;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        if (cnt_q == SWEEP_END) begin
          // Last address was written in the current cycle; signal completion
          // and either chain straight into the pending sweep or go idle.
          done_d = 1'b1;
          if (pend_q || clear_req) begin
            pend_d   = 1'b0;
            color_d  = restart_color;
            cnt_d    = 19'd1;
            wen_d    = 1'b1;
            waddr_d  = 20'd0;
            zdata_d  = Z_CLEAR;
            fbdata_d = restart_color;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          wen_d    = 1'b1;
          waddr_d  = {1'b0, cnt_q};
          zdata_d  = Z_CLEAR;
          fbdata_d = color_q;
          cnt_d    = cnt_q + 19'd1;
          if (clear_req) begin
            // Requests during a sweep collapse into one pending sweep.
            pend_d       = 1'b1;
            pend_color_d = clear_color;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 19'd0;
      color_q      <= 24'd0;
      pend_q       <= 1'b0;
      pend_color_q <= 24'd0;
      wen_q        <= 1'b0;
      waddr_q      <= 20'd0;
      zdata_q      <= 16'd0;
      fbdata_q     <= 24'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      color_q      <= color_d;
      pend_q       <= pend_d;
      pend_color_q <= pend_color_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      zdata_q      <= zdata_d;
      fbdata_q     <= fbdata_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign clear_busy   = busy_q;
  assign clear_done   = done_q;
  assign z_wr_dropped = drop_q;

  // Both memories share one registered write command.
  assign zbuf_wen     = wen_q;
  assign zbuf_waddr   = waddr_q;
  assign zbuf_wdata   = zdata_q;
  assign fb_wen       = wen_q;
  assign fb_waddr     = waddr_q;
  assign fb_wdata     = fbdata_q;

endmodule

// File: tb/tb_frame_mem_write_arbiter.sv
module tb_frame_mem_write_arbiter;

  localparam int          W    = 4;
  localparam int          H    = 2;
  localparam int          N    = W * H;
  localparam logic [15:0] ZC   = 16'h7FFF;
  localparam int          MAXC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic [23:0] clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic        z_wr_valid;
  logic        z_wr_ready;
  logic [19:0] z_wr_addr;
  logic [15:0] z_wr_depth;
  logic [23:0] z_wr_color;
  logic        z_wr_dropped;
  logic        zbuf_wen;
  logic [19:0] zbuf_waddr;
  logic [15:0] zbuf_wdata;
  logic        fb_wen;
  logic [19:0] fb_waddr;
  logic [23:0] fb_wdata;

  always #5 clk = ~clk;

  frame_mem_write_arbiter #(.WIDTH(W), .HEIGHT(H), .Z_CLEAR(ZC)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .z_wr_valid   (z_wr_valid),
    .z_wr_ready   (z_wr_ready),
    .z_wr_addr    (z_wr_addr),
    .z_wr_depth   (z_wr_depth),
    .z_wr_color   (z_wr_color),
    .z_wr_dropped (z_wr_dropped),
    .zbuf_wen     (zbuf_wen),
    .zbuf_waddr   (zbuf_waddr),
    .zbuf_wdata   (zbuf_wdata),
    .fb_wen       (fb_wen),
    .fb_waddr     (fb_waddr),
    .fb_wdata     (fb_wdata)
  );

  // Expected outputs per absolute cycle number, filled in ahead of time by
  // the reference model as requests are issued.
  typedef struct packed {
    logic        wen;
    logic [19:0] addr;
    logic [15:0] depth;
    logic [23:0] color;
    logic        done;
    logic        busy;
    logic        drop;
  } exp_t;

  exp_t        exp_a [0:MAXC+N+4];
  int          cyc;
  int          checks;
  int          errors;
  int          sweep_end;
  logic        pending;
  logic [23:0] pcol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // A sweep started at edge c writes addresses 0..N-1 in cycles c+1..c+N and
  // reports done in cycle c+N+1.
  task automatic start_sweep(input int c, input logic [23:0] col);
    for (int k = 0; k < N; k++) begin
      exp_a[c+1+k].wen   = 1'b1;
      exp_a[c+1+k].addr  = 20'(k);
      exp_a[c+1+k].depth = ZC;
      exp_a[c+1+k].color = col;
      exp_a[c+1+k].busy  = 1'b1;
    end
    exp_a[c+N+1].done = 1'b1;
    sweep_end = c + N;
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then let the
  // model react to the inputs sampled at the closing edge.
  task automatic step(input logic rq, input logic [23:0] cc, input logic v,
                      input logic [19:0] a, input logic [15:0] d,
                      input logic [23:0] col, input logic r);
    exp_t e;
    clear_req   = rq;
    clear_color = cc;
    z_wr_valid  = v;
    z_wr_addr   = a;
    z_wr_depth  = d;
    z_wr_color  = col;
    rst         = r;
    @(negedge clk);
    e = exp_a[cyc];
    chk("zbuf_wen",     {31'd0, zbuf_wen},     {31'd0, e.wen});
    chk("fb_wen",       {31'd0, fb_wen},       {31'd0, e.wen});
    chk("clear_done",   {31'd0, clear_done},   {31'd0, e.done});
    chk("clear_busy",   {31'd0, clear_busy},   {31'd0, e.busy});
    chk("z_wr_dropped", {31'd0, z_wr_dropped}, {31'd0, e.drop});
    chk("z_wr_ready",   {31'd0, z_wr_ready},   {31'd0, (!e.busy && !rq)});
    if (e.wen) begin
      chk("zbuf_waddr", {12'd0, zbuf_waddr}, {12'd0, e.addr});
      chk("fb_waddr",   {12'd0, fb_waddr},   {12'd0, e.addr});
      chk("zbuf_wdata", {16'd0, zbuf_wdata}, {16'd0, e.depth});
      chk("fb_wdata",   {8'd0, fb_wdata},    {8'd0, e.color});
    end

    if (r) begin
      for (int i = cyc + 1; i <= cyc + N + 1; i++) exp_a[i] = '0;
      sweep_end = -1;
      pending   = 1'b0;
    end else if (!e.busy) begin
      if (rq) begin
        start_sweep(cyc, cc);
      end else if (v) begin
        if (a < 20'(N)) begin
          exp_a[cyc+1].wen   = 1'b1;
          exp_a[cyc+1].addr  = a;
          exp_a[cyc+1].depth = d;
          exp_a[cyc+1].color = col;
        end else begin
          exp_a[cyc+1].drop = 1'b1;
        end
      end
    end else begin
      if (rq) begin
        pending = 1'b1;
        pcol    = cc;
      end
      if (cyc == sweep_end && pending) begin
        start_sweep(cyc, pcol);
        pending = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    sweep_end   = -1;
    pending     = 1'b0;
    pcol        = 24'd0;
    for (int i = 0; i <= MAXC + N + 4; i++) exp_a[i] = '0;

    rst         = 1'b1;
    clear_req   = 1'b0;
    clear_color = 24'd0;
    z_wr_valid  = 1'b0;
    z_wr_addr   = 20'd0;
    z_wr_depth  = 16'd0;
    z_wr_color  = 24'd0;
    @(posedge clk);
    #1;

    // Reset values of the data/address outputs.
    chk("rst_zbuf_waddr", {12'd0, zbuf_waddr}, 32'd0);
    chk("rst_fb_waddr",   {12'd0, fb_waddr},   32'd0);
    chk("rst_zbuf_wdata", {16'd0, zbuf_wdata}, 32'd0);
    chk("rst_fb_wdata",   {8'd0, fb_wdata},    32'd0);
    step(1'b0, 24'd0, 1'b0, 20'd0, 16'd0, 24'd0, 1'b1);
    idle(1);

    // Full sweep of the small frame.
    step(1'b1, 24'h112233, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(10);

    // Idle fragment burst on consecutive cycles.
    step(1'b0, 24'd0, 1'b1, 20'd3, 16'd10, 24'h0A0B0C, 1'b0);
    step(1'b0, 24'd0, 1'b1, 20'd5, 16'd20, 24'h0D0E0F, 1'b0);
    step(1'b0, 24'd0, 1'b1, 20'd7, 16'd30, 24'h102030, 1'b0);
    idle(2);

    // Out-of-range addresses are accepted and dropped.
    step(1'b0, 24'd0, 1'b1, 20'd8, 16'd99, 24'h445566, 1'b0);
    step(1'b0, 24'd0, 1'b1, 20'hFFFFF, 16'd98, 24'h445567, 1'b0);
    idle(2);

    // Clear and fragment together: clear wins, upstream holds the fragment.
    step(1'b1, 24'h123456, 1'b1, 20'd2, 16'h0042, 24'hC0FFEE, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 24'd0, 1'b1, 20'd2, 16'h0042, 24'hC0FFEE, 1'b0);
    idle(2);

    // Pending sweep chained after the first.
    step(1'b1, 24'h111111, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(3);
    step(1'b1, 24'hAABBCC, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(15);

    // Several requests in one sweep collapse; last colour wins.
    step(1'b1, 24'h010101, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    step(1'b1, 24'h020202, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(2);
    step(1'b1, 24'h030303, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(20);

    // Reset in the middle of a sweep with a pending request.
    step(1'b1, 24'h777777, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    step(1'b1, 24'h888888, 1'b0, 20'd0, 16'd0, 24'd0, 1'b0);
    idle(3);
    step(1'b0, 24'd0, 1'b0, 20'd0, 16'd0, 24'd0, 1'b1);
    idle(1);
    step(1'b0, 24'd0, 1'b1, 20'd6, 16'h1234, 24'h654321, 1'b0);
    idle(12);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        rq, v, r;
      logic [19:0] a;
      logic [15:0] d;
      logic [23:0] cc, col;
      rq  = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 299) == 0);
      a   = 20'($urandom_range(0, 11));
      d   = 16'($urandom);
      cc  = 24'($urandom);
      col = 24'($urandom);
      step(rq, cc, v, a, d, col, r);
    end
    idle(N + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
